fetch_unit: RTL and testbench

- RV32I instruction fetch stage, directly upstream of the decode stage.
- Holds the program counter and issues single-word reads to instruction memory, with at most one read outstanding.
- Presents each fetched word with its PC to decode over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute, discarding any in-flight or held stale instruction.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: one outstanding word read, valid/ready hand-off
// to decode, and redirect handling that squashes stale in-flight or held words.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [29:0] redir_word;
    logic        unused_redir_lsbs;

    assign redir_word        = redirect_pc[31:2];
    assign unused_redir_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        case (state_q)
            S_REQ: begin
                // The accepted request still carries the old pc; drop marks its response stale.
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redirect_valid;
                end
                if (redirect_valid) pc_d = redir_word;
            end
            S_WAIT: begin
                if (redirect_valid) pc_d = redir_word;
                if (mem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = mem_resp_data;
                        inst_pc_d = {pc_q, 2'b00};
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle handshake: the held word is never delivered.
                if (redirect_valid) begin
                    pc_d    = redir_word;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 30'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_VECTOR[31:2];
            drop_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {pc_q, 2'b00};
    assign inst_valid    = (state_q == S_HOLD);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model plus a transaction-level
// reference that tracks the next PC decode should see.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk, reset;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_cnt = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_pend = 32'h0;
    logic [31:0] exp_pc = RV;
    logic [31:0] dq[$];
    int          dc[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: inputs are already set by the caller; called just after a negedge.
    task automatic tick();
        logic        pv, pmreq;
        logic [31:0] pinst, paddr;
        mem_resp_valid = mem_busy && (mem_cnt == 0);
        mem_resp_data  = mem_resp_valid ? mem_word(mem_pend) : 32'hDEAD_BEEF;
        #1;
        if (!reset) begin
            chk("pc_track", mem_addr, exp_pc);
            chk("req_while_outstanding", {31'd0, mem_req_valid & mem_busy}, 32'd0);
            if (mem_resp_valid) chk("resp_state", {30'd0, mem_req_valid, inst_valid}, 32'd0);
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_word", inst, mem_word(exp_pc));
            end
        end
        pv = inst_valid; pinst = inst; pmreq = mem_req_valid; paddr = mem_addr;
        @(posedge clk);
        cyc++;
        if (reset) begin
            exp_pc   = RV;
            mem_busy = 1'b0;
        end else begin
            if (mem_resp_valid) mem_busy = 1'b0;
            if (pmreq && mem_req_ready) begin
                mem_busy = 1'b1;
                mem_pend = paddr;
                mem_cnt  = lat - 1;
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (pv && inst_ready) begin
                dq.push_back(exp_pc);
                dc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(negedge clk);
        if (!reset && pv && !inst_ready && !redirect_valid) begin
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, pinst);
        end
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_ivalid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_ipc"}, inst_pc, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, "_addr"}, mem_addr, RV);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic wait_valid(int n);
        int k = 0;
        while (!inst_valid && k < n) begin tick(); k++; end
        chk("timeout_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req(int n);
        int k = 0;
        while (!mem_req_valid && k < n) begin tick(); k++; end
        chk("timeout_req", {31'd0, mem_req_valid}, 32'd1);
    endtask

    task automatic force_pc(logic [31:0] pc);
        mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = pc;
        tick();
        redirect_valid = 1'b0; mem_req_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        check_reset_state("init");

        // Sequential fetch, 1-cycle memory, decode always ready
        for (int i = 0; i < 30 && dq.size() < 3; i++) tick();
        chk("seq_count", {31'd0, dq.size() >= 3}, 32'd1);
        if (dq.size() >= 3) begin
            chk("seq_pc0", dq[0], 32'h100);
            chk("seq_pc1", dq[1], 32'h104);
            chk("seq_pc2", dq[2], 32'h108);
            chk("seq_gap0", dc[1] - dc[0], 32'd3);
            chk("seq_gap1", dc[2] - dc[1], 32'd3);
        end

        // Backpressure at 0x100
        do_reset();
        inst_ready = 1'b0;
        wait_valid(20);
        chk("bp_pc", inst_pc, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_noreq", {31'd0, mem_req_valid}, 32'd0);
            chk("bp_inst", inst, mem_word(32'h100));
        end
        inst_ready = 1'b1;
        tick();
        wait_req(10);
        chk("bp_next_addr", mem_addr, 32'h104);

        // Redirect in HOLD wins over same-cycle ready
        wait_valid(20);
        chk("hold_redir_pc", inst_pc, 32'h104);
        n = dq.size();
        redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("hold_redir_nodeliver", dq.size(), n);
        wait_req(10);
        chk("hold_redir_addr", mem_addr, 32'h200);
        wait_valid(20);
        tick();

        // Redirect in WAIT, 3-cycle memory
        lat = 3;
        force_pc(32'h10);
        chk("wait_req_addr", mem_addr, 32'h10);
        n = dq.size();
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        wait_valid(30);
        chk("wait_redir_ipc", inst_pc, 32'h40);
        tick();
        chk("wait_redir_first", (dq.size() > n) ? dq[n] : 32'hFFFF_FFFF, 32'h40);

        // Redirect coincident with acceptance; unaligned target
        lat = 1;
        force_pc(32'h20);
        n = dq.size();
        mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h83;
        tick();
        redirect_valid = 1'b0;
        chk("coinc_in_wait", {31'd0, mem_req_valid}, 32'd0);
        wait_req(10);
        chk("coinc_addr", mem_addr, 32'h80);
        wait_valid(20);
        tick();
        chk("coinc_first", (dq.size() > n) ? dq[n] : 32'hFFFF_FFFF, 32'h80);

        // PC wrap, then reset while waiting on memory
        force_pc(32'hFFFF_FFFC);
        wait_valid(20);
        chk("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        tick();
        wait_req(10);
        chk("wrap_addr", mem_addr, 32'h0);
        lat = 3;
        tick();
        chk("wrap_in_wait", {31'd0, mem_req_valid | inst_valid}, 32'd0);
        do_reset();
        tick();
        chk("post_reset_wait", mem_addr, RV);

        // Randomized traffic
        n = dq.size();
        for (int i = 0; i < 2000; i++) begin
            lat            = int'($urandom_range(1, 4));
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", {31'd0, (dq.size() - n) > 50}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
